led_pattern_sequencer: RTL
==========================

Name: led_pattern_sequencer

Overview:
- Parametrised, multi-mode LED pattern generator for bicolour status LEDs (colour A = orange, colour B = green, A+B = yellow).
- Replaces fixed-width cascaded-counter flashers with three features: a single prescaler, a selectable pattern mode, and PWM brightness.
- Output is registered and can be active-low, so it drives the board LED pins directly. The top-level wrapper ties the output-enables.

Parameters:
NUM_LEDS, 4, number of bicolour LEDs (valid range 1..16).
TICK_DIV, 134217728, clock cycles per pattern step (valid range 2..2^32).
PWM_BITS, 4, brightness resolution in bits.
ACTIVE_LOW, 1, 1 = lit LED drives 0, 0 = lit LED drives 1.

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous reset, active-high
i_en  in  1  advance enable; 0 freezes prescaler and step
i_mode  in  2  0=FILL, 1=CHASE, 2=BLINK, 3=OFF
i_bright  in  PWM_BITS  duty; 0=dark, all-ones=100%
o_led  out  2*NUM_LEDS  [i]=colour A of LED i, [NUM_LEDS+i]=colour B of LED i
o_step  out  STEP_W  current step index; STEP_W=$clog2(3*NUM_LEDS+1)
o_tick  out  1  one-cycle pulse on every step advance

Behaviour:
- Reset (async assert, sync release):
  - prescaler=0, step=0, pwm counter=0, o_tick=0.
  - Registered mode=0.
  - o_led = all-off: all ones if ACTIVE_LOW, else all zeros.
- Prescaler:
  - Counts 0..TICK_DIV-1 while i_en=1, then wraps to 0.
  - tick = i_en && prescaler==TICK_DIV-1.
  - o_tick is registered; it is high in the cycle after the terminal count.
- Step advance on tick: step = (step==LAST(mode)) ? 0 : step+1.
- FILL, LAST=3N (N=NUM_LEDS):
  - step 0: all off.
  - step k in 1..N: colour A on LEDs 0..k-1.
  - step k in N+1..2N: colour B on LEDs 0..k-N-1.
  - step k in 2N+1..3N: A and B on LEDs 0..k-2N-1.
- CHASE, LAST=3N-1:
  - Exactly one LED lit, index = step mod N.
  - Colour A for step<N, B for step<2N, otherwise A+B.
- BLINK, LAST=1: step 0 all off; step 1 all LEDs A+B.
- OFF: pattern all off; step still advances with LAST=0, so it stays 0.
- Mode change:
  - i_mode is registered each cycle.
  - When i_mode != registered mode: step and prescaler clear to 0 on that edge, and o_tick=0.
  - Mode change has priority over a coincident tick.
- PWM:
  - Free-running PWM_BITS counter; runs regardless of i_en.
  - pwm_on = (i_bright == all-ones) || (pwm_cnt < i_bright).
  - i_bright is used live, without resynchronisation.
- Output:
  - o_led register = (pattern(step) & {2N{pwm_on}}) XOR {2N{ACTIVE_LOW}}.
  - Latency is 1 cycle from the step register to o_led.
  - o_step mirrors the step register.
- i_en=0: step and prescaler hold; o_tick=0; PWM and o_led keep updating.
- i_en low exactly on terminal count: no tick; prescaler holds at TICK_DIV-1 and ticks on the first cycle i_en returns high.
- Step never exceeds LAST(mode); this is guaranteed by the mode-change clear.

Test Plan (NUM_LEDS=4, PWM_BITS=4, ACTIVE_LOW=1, TICK_DIV=4 unless stated):
1. Assert i_rst mid-run (step=7) between clock edges:
   - o_led=8'hFF and o_step=0 immediately, without waiting for a clock.
   - After release, first o_tick occurs 4 cycles later.
2. FILL, i_bright=4'hF, i_en=1:
   - o_tick every 4 cycles; o_step sequence 0..12, then 0.
   - o_led by step: step1=8'hFE, step5=8'hEF, step9=8'hEE, step12=8'h00, wrap=8'hFF.
3. CHASE, i_bright=4'hF:
   - step0=8'hFE, step5=8'hDF, step10=8'hBB, step11=8'h77, then o_step=0.
4. BLINK, i_bright=4'hF: o_led alternates 8'hFF / 8'h00 every 4 cycles.
5. TICK_DIV=64, FILL held at step12:
   - i_bright=4 gives o_led=8'h00 for 4 of every 16 cycles, otherwise 8'hFF.
   - i_bright=0 gives constant 8'hFF.
6. Freeze and mode change:
   - Drop i_en for 10 cycles: o_step constant, o_tick=0.
   - Change i_mode FILL->CHASE on a terminal-count cycle: o_step=0, no o_tick.
   - Next tick comes 4 cycles later.

Source files
------------

// File: rtl/led_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// led_pattern_sequencer
//
// Multi-mode pattern generator for a row of bicolour status LEDs
// (colour A = orange, colour B = green, both together = yellow).
// A single prescaler sets the pattern step rate, i_mode selects the pattern,
// and a free-running PWM counter dims every lit LED. The output is registered
// and optionally inverted so it can drive board LED pins directly.
//
// Parameters:
//   NUM_LEDS   number of bicolour LEDs (1..16)
//   TICK_DIV   clock cycles per pattern step (2..2^32)
//   PWM_BITS   brightness resolution in bits
//   ACTIVE_LOW 1 = a lit LED drives 0, 0 = a lit LED drives 1
//
// Ports:
//   i_clk     system clock
//   i_rst     asynchronous reset, active-high
//   i_en      advance enable; low freezes prescaler and step
//   i_mode    0 = FILL, 1 = CHASE, 2 = BLINK, 3 = OFF
//   i_bright  PWM duty; 0 = dark, all-ones = always on
//   o_led     [i] = colour A of LED i, [NUM_LEDS+i] = colour B of LED i
//   o_step    current step index
//   o_tick    one-cycle pulse on every step advance
// ---------------------------------------------------------------------------
module led_pattern_sequencer #(
    parameter int              NUM_LEDS   = 4,
    parameter longint unsigned TICK_DIV   = 64'd134217728,
    parameter int              PWM_BITS   = 4,
    parameter bit              ACTIVE_LOW = 1'b1,
    localparam int             STEP_W     = $clog2(3 * NUM_LEDS + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [1:0]            i_mode,
    input  logic [PWM_BITS-1:0]   i_bright,
    output logic [2*NUM_LEDS-1:0] o_led,
    output logic [STEP_W-1:0]     o_step,
    output logic                  o_tick
);

    localparam int N       = NUM_LEDS;
    localparam int PRESC_W = (TICK_DIV > 64'd1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PRESC_W-1:0]  PRESC_TERM = PRESC_W'(TICK_DIV - 64'd1);
    localparam logic [2*N-1:0]      LED_OFF    = {(2 * N){ACTIVE_LOW}};

    localparam logic [1:0] MODE_FILL  = 2'd0;
    localparam logic [1:0] MODE_CHASE = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_OFF   = 2'd3;

    localparam logic [STEP_W-1:0] LAST_FILL  = STEP_W'(3 * N);
    localparam logic [STEP_W-1:0] LAST_CHASE = STEP_W'(3 * N - 1);
    localparam logic [STEP_W-1:0] LAST_BLINK = STEP_W'(1);
    localparam logic [STEP_W-1:0] LAST_OFF   = STEP_W'(0);

    logic [PRESC_W-1:0]  r_presc;
    logic [STEP_W-1:0]   r_step;
    logic                r_tick;
    logic [1:0]          r_mode;
    logic [PWM_BITS-1:0] r_pwmCnt;
    logic [2*N-1:0]      r_led;

    logic                w_modeChange;
    logic                w_tick;
    logic                w_pwmOn;
    logic [STEP_W-1:0]   w_last;
    logic [2*N-1:0]      w_pattern;
    int                  w_k;
    int                  w_chaseIdx;

    // A mode change restarts the pattern; a tick is the prescaler sitting
    // on its terminal count while advancing is enabled.
    assign w_modeChange = (i_mode != r_mode);
    assign w_tick       = i_en && (r_presc == PRESC_TERM);

    // Full-scale brightness is forced on, since the counter can never
    // exceed the all-ones value and would otherwise leave one dark slot.
    assign w_pwmOn = (&i_bright) || (r_pwmCnt < i_bright);

    // Last step index of the currently running pattern; the step wraps to
    // zero after reaching it.
    always_comb begin
        w_last = LAST_OFF;
        case (r_mode)
            MODE_FILL:  w_last = LAST_FILL;
            MODE_CHASE: w_last = LAST_CHASE;
            MODE_BLINK: w_last = LAST_BLINK;
            MODE_OFF:   w_last = LAST_OFF;
            default:    w_last = LAST_OFF;
        endcase
    end

    // Decode the current step into the raw (active-high, undimmed) pattern.
    // The chase index is step mod N, done with range compares because the
    // step never reaches 3N in CHASE mode.
    always_comb begin
        w_pattern = '0;
        w_k       = int'(r_step);
        if (w_k >= 2 * N) begin
            w_chaseIdx = w_k - 2 * N;
        end else if (w_k >= N) begin
            w_chaseIdx = w_k - N;
        end else begin
            w_chaseIdx = w_k;
        end

        case (r_mode)
            MODE_FILL: begin
                for (int i = 0; i < N; i++) begin
                    if (w_k >= 1 && w_k <= N) begin
                        w_pattern[i] = (i < w_k);
                    end else if (w_k > N && w_k <= 2 * N) begin
                        w_pattern[N+i] = (i < w_k - N);
                    end else if (w_k > 2 * N) begin
                        w_pattern[i]   = (i < w_k - 2 * N);
                        w_pattern[N+i] = (i < w_k - 2 * N);
                    end
                end
            end
            MODE_CHASE: begin
                for (int i = 0; i < N; i++) begin
                    if (i == w_chaseIdx) begin
                        if (w_k < N) begin
                            w_pattern[i] = 1'b1;
                        end else if (w_k < 2 * N) begin
                            w_pattern[N+i] = 1'b1;
                        end else begin
                            w_pattern[i]   = 1'b1;
                            w_pattern[N+i] = 1'b1;
                        end
                    end
                end
            end
            MODE_BLINK: begin
                if (r_step == LAST_BLINK) begin
                    w_pattern = '1;
                end
            end
            default: begin
                w_pattern = '0;
            end
        endcase
    end

    // Prescaler, step counter and tick pulse. A mode change wins over a
    // coincident tick so the new pattern always starts cleanly at step 0.
    // With i_en low everything holds, including a prescaler parked on its
    // terminal count, which then ticks as soon as i_en returns.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mode  <= MODE_FILL;
            r_presc <= '0;
            r_step  <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_mode <= i_mode;
            if (w_modeChange) begin
                r_presc <= '0;
                r_step  <= '0;
                r_tick  <= 1'b0;
            end else if (i_en) begin
                r_tick <= w_tick;
                if (w_tick) begin
                    r_presc <= '0;
                    r_step  <= (r_step == w_last) ? '0 : r_step + STEP_W'(1);
                end else begin
                    r_presc <= r_presc + PRESC_W'(1);
                end
            end else begin
                r_tick <= 1'b0;
            end
        end
    end

    // Free-running PWM counter; it keeps running while stepping is frozen
    // so brightness stays steady on a held pattern.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pwmCnt <= '0;
        end else begin
            r_pwmCnt <= r_pwmCnt + PWM_BITS'(1);
        end
    end

    // Registered LED drive: pattern gated by PWM, then flipped to the pin
    // polarity so reset leaves every LED dark.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_led <= LED_OFF;
        end else begin
            r_led <= (w_pattern & {(2 * N){w_pwmOn}}) ^ LED_OFF;
        end
    end

    assign o_led  = r_led;
    assign o_step = r_step;
    assign o_tick = r_tick;

endmodule
